// File: rtl/board_pkg.sv
// Shared cell encodings, FSM state type and board indexing helper for board_tracker.
package board_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_X     = 2'b01;
   localparam logic [1:0] CELL_O     = 2'b10;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      CHECK = 2'd1,
      OVER  = 2'd2
   } state_t;

   // Row-major flat index of a board cell.
   function automatic int cell_idx(input int row, input int col, input int n);
      return row * n + col;
   endfunction

endpackage

// File: rtl/board_line_check.sv
// One line (row, column or diagonal) of N cells: wins when all cells match and are occupied.
module board_line_check
   import board_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [2*N-1:0] line,
   output logic           win,
   output logic [1:0]     who
);

   always_comb begin
      win = (line[1:0] != CELL_EMPTY);
      for (int i = 1; i < N; i++) begin
         if (line[2*i +: 2] != line[1:0]) win = 1'b0;
      end
      who = win ? line[1:0] : CELL_EMPTY;
   end

endmodule

// File: rtl/board_tracker.sv
// Registered N x N game board: accepts moves over valid/ready, enforces turns, detects win and draw.
module board_tracker
   import board_pkg::*;
#(
   parameter  int N     = 3,
   localparam int IDX_W = $clog2(N),
   localparam int CNT_W = $clog2(N*N+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               new_game,
   input  logic               move_valid,
   output logic               move_ready,
   input  logic [IDX_W-1:0]   move_row,
   input  logic [IDX_W-1:0]   move_col,
   input  logic [1:0]         move_player,
   output logic               move_ack,
   output logic               move_err,
   output logic [1:0]         turn,
   output logic [CNT_W-1:0]   fill_count,
   output logic               filled,
   output logic [1:0]         winner,
   output logic               game_over,
   output logic               draw,
   output logic [2*N*N-1:0]   board,
   output state_t             fsm_state
);

   localparam int CIDX_W = $clog2(N*N);
   localparam int LINES  = 2*N + 2;

   state_t                 state, next_state;
   logic [N*N-1:0][1:0]    cells;
   logic [2*N-1:0]         lines [LINES];
   logic [LINES-1:0]       line_win;
   logic [1:0]             line_who [LINES];
   logic                   any_win;
   logic [1:0]             win_who;
   logic                   in_range;
   logic [CIDX_W-1:0]      target_idx;
   logic [1:0]             target_cell;
   logic                   handshake;
   logic                   legal;

   assign board      = cells;
   assign fsm_state  = state;
   assign filled     = (fill_count == CNT_W'(N*N));
   // Handshake: a move transfers on an edge where move_valid and move_ready are both high;
   // move_ready depends only on state, and the requester holds operands until the transfer.
   assign move_ready = (state == PLAY);
   assign handshake  = move_valid && move_ready;

   assign in_range    = (32'(move_row) < N) && (32'(move_col) < N);
   assign target_idx  = CIDX_W'(cell_idx(32'(move_row), 32'(move_col), N));
   assign target_cell = in_range ? cells[target_idx] : CELL_X;
   assign legal       = handshake && in_range && (target_cell == CELL_EMPTY) && (move_player == turn);

   always_comb begin
      lines = '{default: '0};
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            lines[r][2*c +: 2]   = cells[r*N + c];
            lines[N+c][2*r +: 2] = cells[r*N + c];
         end
      end
      for (int i = 0; i < N; i++) begin
         lines[2*N][2*i +: 2]   = cells[i*N + i];
         lines[2*N+1][2*i +: 2] = cells[i*N + (N-1-i)];
      end
   end

   for (genvar k = 0; k < LINES; k++) begin : g_line
      board_line_check #(.N(N)) u_line (
         .line (lines[k]),
         .win  (line_win[k]),
         .who  (line_who[k])
      );
   end

   always_comb begin
      any_win = 1'b0;
      win_who = CELL_EMPTY;
      for (int k = 0; k < LINES; k++) begin
         if (line_win[k] && !any_win) begin
            any_win = 1'b1;
            win_who = line_who[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || new_game) state <= PLAY;
      else                    state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         PLAY:    if (legal) next_state = CHECK;
         CHECK:   next_state = (any_win || filled) ? OVER : PLAY;
         OVER:    next_state = OVER;
         default: next_state = PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || new_game) begin
         cells      <= '0;
         fill_count <= '0;
         winner     <= CELL_EMPTY;
         draw       <= 1'b0;
         game_over  <= 1'b0;
         turn       <= CELL_X;
         move_ack   <= 1'b0;
         move_err   <= 1'b0;
      end else begin
         move_ack <= 1'b0;
         move_err <= 1'b0;
         case (state)
            PLAY: begin
               if (legal) begin
                  cells[target_idx] <= move_player;
                  fill_count        <= fill_count + 1'b1;
                  move_ack          <= 1'b1;
               end else if (handshake) begin
                  move_err <= 1'b1;
               end
            end
            CHECK: begin
               // A winning line takes priority over a full board.
               if (any_win) begin
                  winner    <= win_who;
                  game_over <= 1'b1;
               end else if (filled) begin
                  draw      <= 1'b1;
                  game_over <= 1'b1;
               end else begin
                  turn <= (turn == CELL_X) ? CELL_O : CELL_X;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_board_tracker.sv
// Directed table-driven bench for board_tracker with N=3 and N=4 instances.
module tb_board_tracker;
   import board_pkg::*;

   localparam logic [1:0] PX = 2'b01;
   localparam logic [1:0] PO = 2'b10;

   logic clk = 1'b0;
   logic rst_n;
   logic ng3, ng4, valid3, valid4;
   logic [1:0] move_row, move_col, move_player;

   logic ready3, ack3, err3, filled3, over3, draw3;
   logic [1:0] turn3, winner3;
   logic [3:0] fill3;
   logic [17:0] board3;
   state_t fsm3;

   logic ready4, ack4, err4, filled4, over4, draw4;
   logic [1:0] turn4, winner4;
   logic [4:0] fill4;
   logic [31:0] board4;
   state_t fsm4;

   int checks = 0;
   int errors = 0;
   logic [17:0] mb3;
   logic [31:0] mb4;

   always #5 clk = ~clk;

   board_tracker #(.N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .new_game(ng3), .move_valid(valid3), .move_ready(ready3),
      .move_row(move_row), .move_col(move_col), .move_player(move_player),
      .move_ack(ack3), .move_err(err3), .turn(turn3), .fill_count(fill3), .filled(filled3),
      .winner(winner3), .game_over(over3), .draw(draw3), .board(board3), .fsm_state(fsm3)
   );

   board_tracker #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .new_game(ng4), .move_valid(valid4), .move_ready(ready4),
      .move_row(move_row), .move_col(move_col), .move_player(move_player),
      .move_ack(ack4), .move_err(err4), .turn(turn4), .fill_count(fill4), .filled(filled4),
      .winner(winner4), .game_over(over4), .draw(draw4), .board(board4), .fsm_state(fsm4)
   );

   typedef struct {
      bit         ng;
      logic [1:0] r, c, p;
      bit         ack, err;
      int         fill;
      logic [1:0] turn, win;
      bit         over, draw;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_ng(input bit sel);
      @(negedge clk);
      if (sel) ng4 = 1'b1; else ng3 = 1'b1;
      @(negedge clk);
      ng3 = 1'b0;
      ng4 = 1'b0;
   endtask

   task automatic do_move(input bit sel, input logic [1:0] r, input logic [1:0] c,
                          input logic [1:0] p, output logic ack, output logic err);
      int waited = 0;
      @(negedge clk);
      move_row = r;
      move_col = c;
      move_player = p;
      if (sel) valid4 = 1'b1; else valid3 = 1'b1;
      while (!(sel ? ready4 : ready3) && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 8) begin
         checks++;
         errors++;
         $display("FAIL ready_wait: move_ready stayed 0 for %0d cycles, required 1", waited);
      end
      @(posedge clk);
      #1;
      ack = sel ? ack4 : ack3;
      err = sel ? err4 : err3;
      @(negedge clk);
      valid3 = 1'b0;
      valid4 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input int i);
      vec_t v;
      logic a, e;
      v = vecs[i];
      if (v.ng) begin
         pulse_ng(1'b0);
         mb3 = '0;
      end
      do_move(1'b0, v.r, v.c, v.p, a, e);
      if (v.ack) mb3[2*(int'(v.r)*3 + int'(v.c)) +: 2] = v.p;
      chk($sformatf("v%0d_ack", i), a, v.ack);
      chk($sformatf("v%0d_err", i), e, v.err);
      chk($sformatf("v%0d_fill", i), fill3, v.fill);
      chk($sformatf("v%0d_filled", i), filled3, (v.fill == 9));
      chk($sformatf("v%0d_turn", i), turn3, v.turn);
      chk($sformatf("v%0d_winner", i), winner3, v.win);
      chk($sformatf("v%0d_over", i), over3, v.over);
      chk($sformatf("v%0d_draw", i), draw3, v.draw);
      chk($sformatf("v%0d_board", i), board3, mb3);
   endtask

   task automatic move4(input logic [1:0] r, input logic [1:0] c, input logic [1:0] p,
                        input logic [1:0] exp_turn, input logic [1:0] exp_win);
      logic a, e;
      do_move(1'b1, r, c, p, a, e);
      mb4[2*(int'(r)*4 + int'(c)) +: 2] = p;
      chk($sformatf("n4_%0d%0d_ack", r, c), a, 1'b1);
      chk($sformatf("n4_%0d%0d_board", r, c), board4, mb4);
      chk($sformatf("n4_%0d%0d_turn", r, c), turn4, exp_turn);
      chk($sformatf("n4_%0d%0d_winner", r, c), winner4, exp_win);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // X wins the top row
      vecs[0]  = '{1, 0, 0, PX, 1, 0, 1, PO, 2'b00, 0, 0};
      vecs[1]  = '{0, 1, 1, PO, 1, 0, 2, PX, 2'b00, 0, 0};
      vecs[2]  = '{0, 0, 1, PX, 1, 0, 3, PO, 2'b00, 0, 0};
      vecs[3]  = '{0, 2, 2, PO, 1, 0, 4, PX, 2'b00, 0, 0};
      vecs[4]  = '{0, 0, 2, PX, 1, 0, 5, PX, PX,    1, 0};
      // illegal moves
      vecs[5]  = '{1, 0, 0, PO, 0, 1, 0, PX, 2'b00, 0, 0};
      vecs[6]  = '{0, 0, 0, PX, 1, 0, 1, PO, 2'b00, 0, 0};
      vecs[7]  = '{0, 0, 0, PO, 0, 1, 1, PO, 2'b00, 0, 0};
      vecs[8]  = '{0, 3, 0, PO, 0, 1, 1, PO, 2'b00, 0, 0};
      vecs[9]  = '{0, 1, 0, 2'b11, 0, 1, 1, PO, 2'b00, 0, 0};
      vecs[10] = '{0, 1, 0, PX, 0, 1, 1, PO, 2'b00, 0, 0};
      // nine-move draw: X O X / X O O / O X X
      vecs[11] = '{1, 0, 0, PX, 1, 0, 1, PO, 2'b00, 0, 0};
      vecs[12] = '{0, 0, 1, PO, 1, 0, 2, PX, 2'b00, 0, 0};
      vecs[13] = '{0, 0, 2, PX, 1, 0, 3, PO, 2'b00, 0, 0};
      vecs[14] = '{0, 1, 1, PO, 1, 0, 4, PX, 2'b00, 0, 0};
      vecs[15] = '{0, 1, 0, PX, 1, 0, 5, PO, 2'b00, 0, 0};
      vecs[16] = '{0, 1, 2, PO, 1, 0, 6, PX, 2'b00, 0, 0};
      vecs[17] = '{0, 2, 1, PX, 1, 0, 7, PO, 2'b00, 0, 0};
      vecs[18] = '{0, 2, 0, PO, 1, 0, 8, PX, 2'b00, 0, 0};
      vecs[19] = '{0, 2, 2, PX, 1, 0, 9, PX, 2'b00, 1, 1};

      rst_n = 1'b0;
      ng3 = 1'b0; ng4 = 1'b0; valid3 = 1'b0; valid4 = 1'b0;
      move_row = '0; move_col = '0; move_player = '0;
      mb3 = '0; mb4 = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_board3", board3, 18'h0);
      chk("rst_fill3", fill3, 4'd0);
      chk("rst_turn3", turn3, PX);
      chk("rst_ready3", ready3, 1'b1);
      chk("rst_status3", {ack3, err3, winner3, over3, draw3, filled3}, 7'b0);
      chk("rst_state3", fsm3, PLAY);
      chk("rst_board4", board4, 32'h0);
      chk("rst_status4", {ack4, err4, winner4, over4, draw4, filled4, fill4}, 12'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) apply_vec(i);

      // moves offered in OVER are neither acked nor rejected; board holds
      @(negedge clk);
      move_row = 2'd1; move_col = 2'd0; move_player = PX;
      valid3 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("over_%0d_ackerr", k), {ack3, err3}, 2'b00);
         chk($sformatf("over_%0d_ready", k), ready3, 1'b0);
         chk($sformatf("over_%0d_board", k), board3, mb3);
      end
      @(negedge clk);
      valid3 = 1'b0;

      for (int i = 5; i < 20; i++) apply_vec(i);

      // N=4: X takes the anti-diagonal, using row 3 and col 3
      pulse_ng(1'b1);
      mb4 = '0;
      move4(2'd0, 2'd3, PX, PO, 2'b00);
      move4(2'd0, 2'd0, PO, PX, 2'b00);
      move4(2'd1, 2'd2, PX, PO, 2'b00);
      move4(2'd0, 2'd1, PO, PX, 2'b00);
      move4(2'd2, 2'd1, PX, PO, 2'b00);
      move4(2'd0, 2'd2, PO, PX, 2'b00);
      move4(2'd3, 2'd0, PX, PX, PX);
      chk("n4_over", over4, 1'b1);
      chk("n4_draw", draw4, 1'b0);
      chk("n4_fill", fill4, 5'd7);

      // new_game together with move_valid, first in OVER then in PLAY
      @(negedge clk);
      ng4 = 1'b1; valid4 = 1'b1;
      move_row = 2'd0; move_col = 2'd0; move_player = PX;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ng4_%0d_board", k), board4, 32'h0);
         chk($sformatf("ng4_%0d_ack", k), {ack4, err4}, 2'b00);
         chk($sformatf("ng4_%0d_fill", k), fill4, 5'd0);
         chk($sformatf("ng4_%0d_status", k), {winner4, over4, draw4}, 4'b0);
         chk($sformatf("ng4_%0d_ready", k), ready4, 1'b1);
         chk($sformatf("ng4_%0d_turn", k), turn4, PX);
         @(negedge clk);
      end
      ng4 = 1'b0; valid4 = 1'b0;

      // reset pulse while dut3 is in CHECK
      pulse_ng(1'b0);
      @(negedge clk);
      move_row = 2'd0; move_col = 2'd0; move_player = PX;
      valid3 = 1'b1;
      @(posedge clk);
      #1;
      chk("midchk_ack", ack3, 1'b1);
      chk("midchk_state", fsm3, CHECK);
      @(negedge clk);
      valid3 = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_board", board3, 18'h0);
      chk("midrst_fill", fill3, 4'd0);
      chk("midrst_turn", turn3, PX);
      chk("midrst_ready", ready3, 1'b1);
      chk("midrst_status", {ack3, err3, winner3, over3, draw3}, 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic a, e;
         do_move(1'b0, 2'd1, 2'd1, PX, a, e);
         chk("postrst_ack", {a, e}, 2'b10);
         chk("postrst_fill", fill3, 4'd1);
         chk("postrst_turn", turn3, PO);
         chk("postrst_board", board3, 18'h0_0100);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
